// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared Q8.8 types, limits and helpers for the SNN neuron blocks
package snn_pkg;

    typedef logic signed [15:0] q8_8_t;

    localparam int    FRAC_BITS         = 8;
    localparam q8_8_t SAT_MAX           = 16'sh7FFF;
    localparam q8_8_t SAT_MIN           = 16'sh8000;
    localparam q8_8_t THRESHOLD_DEFAULT = 16'sh3200;
    localparam q8_8_t V_RESET_DEFAULT   = 16'sh0000;

    // Per-bit two-of-three majority.
    function automatic logic [15:0] vote3(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/lif_lane.sv
// rtl/lif_lane.sv - one LIF membrane update: leak/integrate, saturate, fire, reset
module lif_lane
    import snn_pkg::*;
#(
    parameter q8_8_t THRESHOLD = THRESHOLD_DEFAULT,
    parameter q8_8_t V_RESET   = V_RESET_DEFAULT
) (
    input  q8_8_t v_in,
    input  q8_8_t i_in,
    input  q8_8_t dt_tau,
    output q8_8_t v_out,
    output logic  spike
);

    logic signed [16:0] diff;
    logic signed [32:0] prod;
    logic signed [32:0] step;
    logic signed [33:0] sum;
    q8_8_t              v_next;

    assign diff = 17'(i_in) - 17'(v_in);
    assign prod = 33'(diff) * 33'(dt_tau);
    assign step = prod >>> FRAC_BITS;
    assign sum  = 34'(v_in) + 34'(step);

    // Clamp the wide sum back into Q8.8 before the threshold compare.
    always_comb begin
        v_next = sum[15:0];
        if (sum > 34'(SAT_MAX)) begin
            v_next = SAT_MAX;
        end else if (sum < 34'(SAT_MIN)) begin
            v_next = SAT_MIN;
        end
    end

    assign spike = (v_next >= THRESHOLD);
    assign v_out = spike ? V_RESET : v_next;

endmodule

// File: rtl/tmr_lif_neuron.sv
// rtl/tmr_lif_neuron.sv - triple-redundant LIF neuron step with majority-voted registered outputs
module tmr_lif_neuron
    import snn_pkg::*;
#(
    parameter q8_8_t THRESHOLD = THRESHOLD_DEFAULT,
    parameter q8_8_t V_RESET   = V_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] V_in1,
    input  logic [15:0] V_in2,
    input  logic [15:0] V_in3,
    input  logic [15:0] I_in1,
    input  logic [15:0] I_in2,
    input  logic [15:0] I_in3,
    input  logic [15:0] dt_tau,
    output logic [15:0] V_out,
    output logic        spike
);

    q8_8_t lane_v [3];
    logic  lane_s [3];
    q8_8_t v_in   [3];
    q8_8_t i_in   [3];

    assign v_in[0] = V_in1;
    assign v_in[1] = V_in2;
    assign v_in[2] = V_in3;
    assign i_in[0] = I_in1;
    assign i_in[1] = I_in2;
    assign i_in[2] = I_in3;

    for (genvar n = 0; n < 3; n++) begin : g_lane
        lif_lane #(
            .THRESHOLD (THRESHOLD),
            .V_RESET   (V_RESET)
        ) u_lane (
            .v_in   (v_in[n]),
            .i_in   (i_in[n]),
            .dt_tau (dt_tau),
            .v_out  (lane_v[n]),
            .spike  (lane_s[n])
        );
    end

    logic [15:0] v_vote;
    logic        spike_vote;

    // Bitwise vote may yield a value matching no lane when two lanes disagree.
    assign v_vote     = vote3(lane_v[0], lane_v[1], lane_v[2]);
    assign spike_vote = (lane_s[0] & lane_s[1]) | (lane_s[1] & lane_s[2]) | (lane_s[0] & lane_s[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            V_out <= 16'h0000;
            spike <= 1'b0;
        end else begin
            V_out <= v_vote;
            spike <= spike_vote;
        end
    end

endmodule

// File: tb/tb_tmr_lif_neuron.sv
// tb/tb_tmr_lif_neuron.sv - directed self-checking bench for tmr_lif_neuron
module tb_tmr_lif_neuron;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] V_in1 = '0, V_in2 = '0, V_in3 = '0;
    logic [15:0] I_in1 = '0, I_in2 = '0, I_in3 = '0;
    logic [15:0] dt_tau = '0;
    logic [15:0] V_out;
    logic        spike;

    int checks = 0;
    int passes = 0;

    tmr_lif_neuron dut (
        .clk    (clk),
        .rst    (rst),
        .V_in1  (V_in1),
        .V_in2  (V_in2),
        .V_in3  (V_in3),
        .I_in1  (I_in1),
        .I_in2  (I_in2),
        .I_in3  (I_in3),
        .dt_tau (dt_tau),
        .V_out  (V_out),
        .spike  (spike)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] dt,
                         input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3,
                         input logic [15:0] i1, input logic [15:0] i2, input logic [15:0] i3);
        @(negedge clk);
        dt_tau = dt;
        V_in1 = v1; V_in2 = v2; V_in3 = v3;
        I_in1 = i1; I_in2 = i2; I_in3 = i3;
    endtask

    task automatic step(input string tag,
                        input logic [15:0] dt,
                        input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3,
                        input logic [15:0] i1, input logic [15:0] i2, input logic [15:0] i3,
                        input logic [15:0] exp_v, input logic exp_s);
        drive(dt, v1, v2, v3, i1, i2, i3);
        @(posedge clk);
        #1;
        check({tag, "_v"}, 32'(V_out), 32'(exp_v));
        check({tag, "_s"}, 32'(spike), 32'(exp_s));
    endtask

    initial begin
        #2;
        check("reset_v", 32'(V_out), 32'h0);
        check("reset_s", 32'(spike), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        step("integrate",   16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
        step("lane1_fault", 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h1200, 16'h1000, 16'h1000, 16'h1000, 1'b0);
        step("fire_all",    16'h0080, 16'h3200, 16'h3200, 16'h3200, 16'h6000, 16'h6000, 16'h6000, 16'h0000, 1'b1);
        step("fire_2of3",   16'h0080, 16'h0000, 16'h3200, 16'h3200, 16'h6000, 16'h6000, 16'h6000, 16'h0000, 1'b1);
        step("neg_sat",     16'h0400, 16'h9000, 16'h9000, 16'h9000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
        // Large positive excursion saturates to 0x7FFF, which fires and resets.
        step("pos_sat",     16'h0400, 16'h7000, 16'h7000, 16'h7000, 16'h7F00, 16'h7F00, 16'h7F00, 16'h0000, 1'b1);
        step("thr_equal",   16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h3200, 16'h3200, 16'h3200, 16'h0000, 1'b1);
        step("thr_below",   16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h31FF, 16'h31FF, 16'h31FF, 16'h31FF, 1'b0);
        step("vote_none",   16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0000, 1'b0);
        step("vote_mix",    16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0005, 16'h0006, 16'h0007, 1'b0);
        // -1 * 0.5 = -0x80 raw; arithmetic shift gives -1 LSB, cancelling v=1.
        step("ashift",      16'h0080, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("leak",        16'h0040, 16'h2000, 16'h2000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h1800, 1'b0);

        step("pre_rst",     16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_v", 32'(V_out), 32'h0);
        check("async_rst_s", 32'(spike), 32'h0);
        @(posedge clk);
        #1;
        check("held_rst_v", 32'(V_out), 32'h0);
        drive(16'h0080, 16'h3200, 16'h3200, 16'h3200, 16'h6000, 16'h6000, 16'h6000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_v", 32'(V_out), 32'h0);
        check("post_rst_s", 32'(spike), 32'h1);
        step("spike_drop",  16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
